ica_fetch_responder: RTL and testbench

ICA_FETCH_RESPONDER -- requirements
Module: ica_fetch_responder

---
 rtl/ica_fetch_responder_if.sv | 24 ++
 rtl/ica_fetch_responder.sv | 93 +++++++++
 tb/tb_ica_fetch_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ica_fetch_responder_if.sv
// Fetch-side, backing-memory and snoop signals of the instruction fetch responder.
interface ica_fetch_responder_if;
    logic [21:0] address;
    logic        as;
    logic [15:0] dout;
    logic        bus_ack;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        snoop_we;
    logic [21:0] snoop_addr;

    modport slave (
        input  address, as, mem_ready, mem_valid, mem_rdata, snoop_we, snoop_addr,
        output dout, bus_ack, mem_req, mem_addr
    );

    modport master (
        output address, as, mem_ready, mem_valid, mem_rdata, snoop_we, snoop_addr,
        input  dout, bus_ack, mem_req, mem_addr
    );
endinterface

// File: rtl/ica_fetch_responder.sv
// Halfword fetch responder with a single-longword read buffer kept coherent
// by snooping other masters' writes.
module ica_fetch_responder #(
    parameter int BUFFER_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ica_fetch_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, ACK} state_t;

    state_t      state, state_nxt;
    logic [20:0] txn_addr;   // latched address[21:1]
    logic        abort;      // fetcher gave up; finish the fill silently
    logic        stale;      // pending line was written during the fill
    logic        buf_valid;
    logic [19:0] buf_tag;
    logic [31:0] buf_data;
    logic [15:0] dout_q;

    logic start, hit, fill, busy, snoop_buf, snoop_txn;
    logic unused_bits;

    assign start     = (state == IDLE) && bus.as;
    assign busy      = (state == MREQ) || (state == MWAIT);
    assign fill      = (state == MWAIT) && bus.mem_valid;
    assign snoop_buf = bus.snoop_we && (bus.snoop_addr[21:2] == buf_tag);
    assign snoop_txn = bus.snoop_we && (bus.snoop_addr[21:2] == txn_addr[20:1]);
    // A write landing on the buffered line in the same cycle wins over the hit.
    assign hit       = (BUFFER_EN != 0) && buf_valid &&
                       (bus.address[21:2] == buf_tag) && !snoop_buf;
    assign unused_bits = ^{bus.address[0], bus.snoop_addr[1:0]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.as)        state_nxt = hit ? ACK : MREQ;
            MREQ:    if (bus.mem_ready) state_nxt = MWAIT;
            MWAIT:   if (bus.mem_valid) state_nxt = ACK;
            ACK:                        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.bus_ack  = (state == ACK) && !abort;
        bus.mem_req  = (state == MREQ);
        bus.mem_addr = txn_addr[20:1];
        bus.dout     = dout_q;
    end

    // Transaction latch, read buffer and data out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_addr  <= '0;
            abort     <= 1'b0;
            stale     <= 1'b0;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            dout_q    <= '0;
        end else begin
            if (start) begin
                txn_addr <= bus.address[21:1];
                abort    <= 1'b0;
                stale    <= 1'b0;
                if (hit)
                    dout_q <= bus.address[1] ? buf_data[15:0] : buf_data[31:16];
            end
            if (busy && !bus.as) abort <= 1'b1;
            if (busy && snoop_txn) stale <= 1'b1;
            if (fill) begin
                buf_data  <= bus.mem_rdata;
                buf_tag   <= txn_addr[20:1];
                // A write to the line at any point during the fill leaves it unbuffered.
                buf_valid <= (BUFFER_EN != 0) && !stale && !snoop_txn;
                dout_q    <= txn_addr[0] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
            end else if (snoop_buf) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ica_fetch_responder.sv
// Directed bench for ica_fetch_responder: buffered and unbuffered instances.
module tb_ica_fetch_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   req_cnt = 0;

    ica_fetch_responder_if b();
    ica_fetch_responder_if b0();

    ica_fetch_responder dut (.clk(clk), .reset(reset), .bus(b));
    ica_fetch_responder #(.BUFFER_EN(0)) dut_nb (.clk(clk), .reset(reset), .bus(b0));

    always #5 clk = ~clk;

    // Accepted memory requests on the buffered instance.
    always @(posedge clk) if (b.mem_req && b.mem_ready) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snoop(input logic [21:0] a);
        b.snoop_we = 1'b1;
        b.snoop_addr = a;
        step();
        b.snoop_we = 1'b0;
    endtask

    // snp: 0 none, 1 snoop the line in an MWAIT cycle, 2 snoop in the mem_valid cycle.
    task automatic do_read(input logic [21:0] a, input bit hit, input logic [31:0] rd,
                           input int wait_rdy, input logic [15:0] exp_d,
                           input bit drop_as, input int snp, input bit keep_as);
        b.as = 1'b1;
        b.address = a;
        step();
        if (hit) begin
            chk("hit_ack", b.bus_ack, 1);
            chk("hit_dout", b.dout, exp_d);
            chk("hit_noreq", b.mem_req, 0);
        end else begin
            chk("miss_ack0", b.bus_ack, 0);
            b.address = ~a;
            for (int i = 0; i <= wait_rdy; i++) begin
                chk("mreq", b.mem_req, 1);
                chk("maddr", b.mem_addr, a[21:2]);
                b.mem_ready = (i == wait_rdy);
                step();
            end
            b.mem_ready = 1'b0;
            chk("mreq_drop", b.mem_req, 0);
            b.as = !drop_as;
            if (snp == 1) begin
                b.snoop_we = 1'b1;
                b.snoop_addr = a ^ 22'h2;
            end
            step();
            b.snoop_we = 1'b0;
            b.mem_valid = 1'b1;
            b.mem_rdata = rd;
            if (snp == 2) begin
                b.snoop_we = 1'b1;
                b.snoop_addr = a ^ 22'h2;
            end
            step();
            b.snoop_we = 1'b0;
            b.mem_valid = 1'b0;
            b.address = a;
            chk("miss_ack", b.bus_ack, !drop_as);
            chk("miss_dout", b.dout, exp_d);
        end
        if (!keep_as) b.as = 1'b0;
        step();
        chk("ack_pulse", b.bus_ack, 0);
    endtask

    initial begin
        b.address = '0; b.as = 0; b.mem_ready = 0; b.mem_valid = 0;
        b.mem_rdata = '0; b.snoop_we = 0; b.snoop_addr = '0;
        b0.address = '0; b0.as = 0; b0.mem_ready = 0; b0.mem_valid = 0;
        b0.mem_rdata = '0; b0.snoop_we = 0; b0.snoop_addr = '0;
        step(); step();
        chk("rst_ack", b.bus_ack, 0);
        chk("rst_req", b.mem_req, 0);
        chk("rst_addr", b.mem_addr, 0);
        chk("rst_dout", b.dout, 0);
        reset = 1'b1;
        step();

        // Miss then back-to-back hit on the other halfword with as held.
        do_read(22'h400, 0, 32'h12345678, 0, 16'h1234, 0, 0, 1);
        do_read(22'h402, 1, 32'h0, 0, 16'h5678, 0, 0, 0);
        chk("one_req", req_cnt, 1);

        // Snoop invalidates the buffered line.
        snoop(22'h402);
        do_read(22'h402, 0, 32'hAABBCCDD, 0, 16'hCCDD, 0, 0, 0);
        chk("two_req", req_cnt, 2);

        // mem_ready withheld for 3 cycles.
        snoop(22'h400);
        do_read(22'h400, 0, 32'h12345678, 3, 16'h1234, 0, 0, 0);

        // Abort still fills the buffer.
        do_read(22'h800, 0, 32'h11112222, 0, 16'h1111, 1, 0, 0);
        do_read(22'h802, 1, 32'h0, 0, 16'h2222, 0, 0, 0);

        // Snoop to the pending line: data delivered, line not kept.
        do_read(22'hC00, 0, 32'h33334444, 0, 16'h3333, 0, 1, 0);
        do_read(22'hC02, 0, 32'h55556666, 0, 16'h6666, 0, 0, 0);
        do_read(22'hC00, 1, 32'h0, 0, 16'h5555, 0, 0, 0);

        // Snoop and fill of the same line in one cycle.
        do_read(22'h1000, 0, 32'h77778888, 0, 16'h7777, 0, 2, 0);
        do_read(22'h1002, 0, 32'h9999AAAA, 0, 16'hAAAA, 0, 0, 0);

        // Unbuffered instance: every read misses.
        for (int k = 0; k < 2; k++) begin
            b0.as = 1'b1;
            b0.address = 22'h400;
            step();
            chk("nb_req", b0.mem_req, 1);
            chk("nb_addr", b0.mem_addr, 20'h100);
            b0.mem_ready = 1'b1;
            step();
            b0.mem_ready = 1'b0;
            b0.mem_valid = 1'b1;
            b0.mem_rdata = 32'h12345678;
            step();
            b0.mem_valid = 1'b0;
            chk("nb_ack", b0.bus_ack, 1);
            chk("nb_dout", b0.dout, 16'h1234);
            b0.as = 1'b0;
            step();
        end

        // Reset during MWAIT; late mem_valid ignored; next read misses.
        snoop(22'h400);
        b.as = 1'b1;
        b.address = 22'h400;
        step();
        b.mem_ready = 1'b1;
        step();
        b.mem_ready = 1'b0;
        chk("pre_rst_mwait_req", b.mem_req, 0);
        reset = 1'b0;
        #1;
        chk("arst_ack", b.bus_ack, 0);
        chk("arst_req", b.mem_req, 0);
        chk("arst_addr", b.mem_addr, 0);
        chk("arst_dout", b.dout, 0);
        step();
        reset = 1'b1;
        b.as = 1'b0;
        b.mem_valid = 1'b1;
        b.mem_rdata = 32'hDEADBEEF;
        step();
        b.mem_valid = 1'b0;
        chk("late_valid_ack", b.bus_ack, 0);
        chk("late_valid_dout", b.dout, 0);
        step();
        do_read(22'h400, 0, 32'h12345678, 0, 16'h1234, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
